// File: rtl/spi_pkg.sv
// spi_pkg: FSM state, command record and frame-width helper for spi_master_engine
package spi_pkg;
    localparam int CS_MAX_W = 4;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
    typedef struct packed {
        logic [CS_MAX_W-1:0] cs;
        logic                rd;
        logic                cpol;
        logic                cpha;
    } cmd_t;
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: sclk divider with one-cycle leading/trailing edge strobes
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic iclk,
    input  logic irstn,
    input  logic en,
    input  logic cpol,
    output logic sclk,
    output logic lead,
    output logic trail
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    logic [CW-1:0] cnt;
    logic          ph;
    logic          tick;
    assign tick  = en && cnt == CW'(CLK_DIV - 1);
    assign lead  = tick && !ph;
    assign trail = tick && ph;
    assign sclk  = ph ^ cpol;
    always_ff @(posedge iclk or negedge irstn)
        if (!irstn) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else begin
            cnt <= (!en || tick) ? '0 : cnt + 1'b1;
            ph  <= en && (ph ^ tick);
        end
endmodule

// File: rtl/spi_master_engine.sv
// spi_master_engine: SPI master issuing one rw+addr+data frame per command.
// Define SPI_MODE_SEL_EN to honour cmd_cpol/cmd_cpha; otherwise mode 0 is fixed.
module spi_master_engine
    import spi_pkg::*;
#(
    parameter int NUM_CS  = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    localparam int CS_W   = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
    input  logic              iclk,
    input  logic              irstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CS_W-1:0]   cmd_cs,
    input  logic              cmd_rd,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_cpol,
    input  logic              cmd_cpha,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs
);
    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int TW      = $clog2(CLK_DIV) + 1;
    localparam int BW      = $clog2(FRAME_W);
    state_t             state, state_nx;
    cmd_t               cmd;
    logic [TW-1:0]      tcnt;
    logic [BW-1:0]      bcnt;
    logic [FRAME_W-1:0] tx;
    logic [DATA_W-1:0]  rx;
    logic               mo, ready_q, lead, trail, launch, sample, tdone, accept, bad, act;
    logic               cpol_c, cpha_c, sclk_raw;
`ifdef SPI_MODE_SEL_EN
    assign cpol_c = cmd_cpol;
    assign cpha_c = cmd_cpha;
`else
    logic unused_mode;
    assign unused_mode = cmd_cpol ^ cmd_cpha;
    assign cpol_c = 1'b0;
    assign cpha_c = 1'b0;
`endif
    assign cmd_ready = state == IDLE && ready_q;
    assign accept    = cmd_valid && cmd_ready;
    assign bad       = 32'(cmd_cs) >= NUM_CS;
    assign tdone     = tcnt == TW'(CLK_DIV - 1);
    assign launch    = cmd.cpha ? lead : trail;
    assign sample    = cmd.cpha ? trail : lead;
    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .iclk  (iclk),
        .irstn (irstn),
        .en    (state == SHIFT),
        .cpol  (cmd.cpol),
        .sclk  (sclk_raw),
        .lead  (lead),
        .trail (trail)
    );
    always_ff @(posedge iclk or negedge irstn)
        if (!irstn) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= 1'b1;
        end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bad ? DONE : SETUP;
            SETUP:   if (tdone) state_nx = SHIFT;
            SHIFT:   if (trail && bcnt == BW'(FRAME_W - 1)) state_nx = HOLD;
            HOLD:    if (tdone) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    // Rejected commands keep the previous CPOL so sclk stays quiet.
    always_ff @(posedge iclk or negedge irstn)
        if (!irstn) begin
            cmd       <= '0;
            tcnt      <= '0;
            bcnt      <= '0;
            tx        <= '0;
            rx        <= '0;
            mo        <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            tcnt <= (state_nx != state) ? '0 : tcnt + 1'b1;
            if (accept) begin
                cmd  <= '{cs: CS_MAX_W'(cmd_cs), rd: cmd_rd, cpol: bad ? cmd.cpol : cpol_c, cpha: cpha_c};
                tx   <= {cmd_rd, cmd_addr, cmd_wdata & {DATA_W{!cmd_rd}}};
                rx   <= '0;
                mo   <= 1'b0;
                bcnt <= '0;
            end else begin
                if (launch) begin
                    mo <= tx[FRAME_W-1];
                    tx <= tx << 1;
                end
                if (sample && bcnt >= BW'(1 + ADDR_W)) rx <= DATA_W'({rx, miso});
                if (trail) bcnt <= bcnt + 1'b1;
            end
            if (state_nx == DONE) begin
                rsp_err   <= state == IDLE;
                rsp_rdata <= (state == IDLE || !cmd.rd) ? '0 : rx;
            end
        end
    always_comb begin
        act       = state == SETUP || state == SHIFT || state == HOLD;
        busy      = state != IDLE;
        rsp_valid = state == DONE;
        sclk      = sclk_raw;
        mosi      = act && (cmd.cpha ? mo : tx[FRAME_W-1]);
        for (int i = 0; i < NUM_CS; i++) cs[i] = !(act && cmd.cs == CS_MAX_W'(i));
    end
endmodule

// File: tb/tb_spi_master_engine.sv
// tb_spi_master_engine: directed checks of spi_master_engine against a bench SPI slave model
module tb_spi_master_engine;
    localparam int F = 13;
    logic       iclk = 1'b0;
    logic       irstn = 1'b1;
    logic       cmd_valid, cmd_rd, cmd_cpol, cmd_cpha, miso;
    logic [1:0] cmd_cs;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       cmd_ready, rsp_valid, rsp_err, busy, sclk, mosi;
    logic [7:0] rsp_rdata;
    logic [3:0] cs;
    logic       c2_valid, c2_ready, r2_valid, r2_err, busy2, sclk2, mosi2;
    logic [1:0] c2_cs;
    logic [7:0] r2_rdata;
    logic [2:0] cs2;
    int         ncmp, nfail;
    int         nld, ntr, edges, s_cs, idx;
    logic       s_cpol, s_cpha, sclk_prev, sel_prev, sel;
    logic [7:0] rdv;
    logic [12:0] rec;

    always #5 iclk = ~iclk;

    spi_master_engine dut (
        .iclk(iclk), .irstn(irstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_cs(cmd_cs), .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs(cs)
    );
    spi_master_engine #(.NUM_CS(3)) dut3 (
        .iclk(iclk), .irstn(irstn), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_cs(c2_cs), .cmd_rd(1'b0), .cmd_addr(4'h0), .cmd_wdata(8'h00),
        .cmd_cpol(1'b0), .cmd_cpha(1'b0), .rsp_valid(r2_valid), .rsp_rdata(r2_rdata),
        .rsp_err(r2_err), .busy(busy2), .sclk(sclk2), .mosi(mosi2), .miso(1'b0), .cs(cs2)
    );

    // Slave model: tracks sclk edges while selected, records MOSI, shifts out rdv on data bits.
    assign sel = !cs[2'(s_cs)];
    always @(negedge iclk) begin
        sclk_prev <= sclk;
        sel_prev  <= sel;
        if (!sel) begin
            nld   <= 0;
            ntr   <= 0;
            edges <= 0;
        end else if (!sel_prev) begin
            rec <= '0;
        end else if (sclk != sclk_prev) begin
            edges <= edges + 1;
            if (sclk != s_cpol) begin
                nld <= nld + 1;
                if (!s_cpha) rec <= {rec[11:0], mosi};
            end else begin
                ntr <= ntr + 1;
                if (s_cpha) rec <= {rec[11:0], mosi};
            end
        end
    end
    always_comb begin
        idx  = s_cpha ? nld - 1 : ntr;
        miso = (idx >= 5 && idx < F) ? rdv[3'(12 - idx)] : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int sel_i, input logic rd, input logic [3:0] addr, input logic [7:0] wd,
                        input logic [1:0] mode, output int lat, output logic [3:0] cs_seen);
        int n;
        @(negedge iclk);
        s_cs = sel_i;
`ifdef SPI_MODE_SEL_EN
        {s_cpol, s_cpha} = mode;
`else
        {s_cpol, s_cpha} = 2'b00;
`endif
        {cmd_cpol, cmd_cpha} = mode;
        cmd_cs = 2'(sel_i); cmd_rd = rd; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge iclk);
            n++;
        end
        chk("accept", 32'(n < 100), 32'd1);
        @(posedge iclk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        cs_seen = 4'hF;
        while (!rsp_valid && lat < 200) begin
            cs_seen &= cs;
            @(posedge iclk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, n, acc, rsps, viol;
        logic [3:0] csv;
        logic [1:0] mm;
        logic pol;
        cmd_valid = 0; cmd_rd = 0; cmd_cs = 0; cmd_addr = 0; cmd_wdata = 0; cmd_cpol = 0; cmd_cpha = 0;
        c2_valid = 0; c2_cs = 0; s_cs = 0; s_cpol = 0; s_cpha = 0; rdv = 0;
        #2 irstn = 1'b0;
        #20;
        chk("rst_cs", 32'(cs), 32'hF);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        @(negedge iclk) irstn = 1'b1;
        @(posedge iclk); #1;
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // Mode-0 write to slave 2
        xfer(2, 1'b0, 4'hA, 8'h5C, 2'b00, lat, csv);
        chk("wr_latency", lat, 57);
        chk("wr_cs", 32'(csv), 32'b1011);
        chk("wr_mosi", 32'(rec), 32'h0A5C);
        chk("wr_rdata", 32'(rsp_rdata), 0);
        chk("wr_err", 32'(rsp_err), 0);
        @(posedge iclk); #1;
        chk("wr_pulse", 32'(rsp_valid), 0);
        chk("wr_idle_busy", 32'(busy), 0);
        chk("wr_idle_cs", 32'(cs), 32'hF);

        // Read from slave 1
        rdv = 8'hA7;
        xfer(1, 1'b1, 4'h3, 8'hFF, 2'b00, lat, csv);
        chk("rd_latency", lat, 57);
        chk("rd_cs", 32'(csv), 32'b1101);
        chk("rd_mosi", 32'(rec), 32'h1300);
        chk("rd_rdata", 32'(rsp_rdata), 32'hA7);
        chk("rd_err", 32'(rsp_err), 0);
        repeat (3) @(posedge iclk);
        #1 chk("rd_rdata_hold", 32'(rsp_rdata), 32'hA7);

        // Each SPI mode: write then read back through the slave register
        for (int m = 0; m < 4; m++) begin
            mm = 2'(m);
`ifdef SPI_MODE_SEL_EN
            pol = mm[1];
`else
            pol = 1'b0;
`endif
            xfer(0, 1'b0, 4'h5, 8'h3C, mm, lat, csv);
            chk("mode_wr_mosi", 32'(rec), 32'h053C);
            chk("mode_idle_sclk_wr", 32'(sclk), 32'(pol));
            rdv = rec[7:0];
            xfer(0, 1'b1, 4'h5, 8'h00, mm, lat, csv);
            chk("mode_rd_rdata", 32'(rsp_rdata), 32'h3C);
            chk("mode_rd_latency", lat, 57);
            @(posedge iclk); #1;
            chk("mode_idle_sclk", 32'(sclk), 32'(pol));
        end

        // Out-of-range slave on the 3-select instance
        @(negedge iclk);
        chk("err_ready", 32'(c2_ready), 1);
        c2_cs = 2'd3; c2_valid = 1'b1;
        @(posedge iclk); #1;
        c2_valid = 1'b0;
        chk("err_valid", 32'(r2_valid), 1);
        chk("err_flag", 32'(r2_err), 1);
        chk("err_cs", 32'(cs2), 32'b111);
        @(posedge iclk); #1;
        chk("err_pulse", 32'(r2_valid), 0);
        chk("err_cs_after", 32'(cs2), 32'b111);
        chk("err_sclk", 32'(sclk2), 0);

        // Reset in the middle of a write
        @(negedge iclk);
        s_cs = 3; s_cpol = 0; s_cpha = 0;
        cmd_cs = 2'd3; cmd_rd = 0; cmd_addr = 4'h1; cmd_wdata = 8'h99; cmd_cpol = 0; cmd_cpha = 0;
        cmd_valid = 1'b1;
        @(posedge iclk); #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge iclk); #1;
            n++;
        end while (edges != 6 && n < 200);
        chk("rst_mid_edge6", edges, 6);
        irstn = 1'b0;
        #1;
        chk("rst_mid_cs", 32'(cs), 32'hF);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_sclk", 32'(sclk), 0);
        @(negedge iclk) irstn = 1'b1;
        rsps = 0;
        repeat (80) begin
            @(posedge iclk); #1;
            if (rsp_valid) rsps++;
        end
        chk("rst_mid_no_rsp", rsps, 0);
        xfer(3, 1'b0, 4'h1, 8'h99, 2'b00, lat, csv);
        chk("post_rst_latency", lat, 57);
        chk("post_rst_mosi", 32'(rec), 32'h0199);
        chk("post_rst_cs", 32'(csv), 32'b0111);

        // cmd_valid held high across three commands
        @(negedge iclk);
        s_cs = 0;
        cmd_cs = 2'd0; cmd_rd = 0; cmd_addr = 4'h2; cmd_wdata = 8'h11; cmd_cpol = 0; cmd_cpha = 0;
        cmd_valid = 1'b1;
        acc = 0; rsps = 0; viol = 0; n = 0;
        while (rsps < 3 && n < 400) begin
            if (cmd_valid && cmd_ready) begin
                acc++;
                if (cs !== 4'hF || busy) viol++;
            end
            @(posedge iclk); #1;
            if (acc == 3) cmd_valid = 1'b0;
            if (rsp_valid) rsps++;
            @(negedge iclk);
            n++;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", acc, 3);
        chk("b2b_rsps", rsps, 3);
        chk("b2b_idle_only", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/spi_master_engine.md
SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

Interface
REQ-001 The module SHALL have parameter NUM_CS, default 4, meaning number of active-low chip selects (1..16).
REQ-002 The module SHALL have parameter ADDR_W, default 4, meaning SPI register address width in bits.
REQ-003 The module SHALL have parameter DATA_W, default 8, meaning SPI data width in bits.
REQ-004 The module SHALL have parameter CLK_DIV, default 2, meaning iclk cycles per sclk half-period (>=1).
REQ-005 The module SHALL have port iclk, input, 1, sole clock; all logic rising-edge.
REQ-006 The module SHALL have port irstn, input, 1, reset, asynchronous, active-low.
REQ-007 The module SHALL have ports cmd_valid input 1 and cmd_ready output 1, forming the command handshake.
REQ-008 The module SHALL have ports cmd_cs input $clog2(NUM_CS) (min 1) slave index, cmd_rd input 1 (1=read), cmd_addr input ADDR_W, cmd_wdata input DATA_W.
REQ-009 The module SHALL have ports cmd_cpol input 1 and cmd_cpha input 1, giving the per-command SPI mode.
REQ-010 The module SHALL have ports rsp_valid output 1 (one-cycle pulse), rsp_rdata output DATA_W, rsp_err output 1.
REQ-011 The module SHALL have ports busy output 1, sclk output 1, mosi output 1, miso input 1, cs output NUM_CS (active-low).

Function
REQ-012 Frame SHALL be FRAME_W = 1+ADDR_W+DATA_W bits, MSB first: rw bit, address, data; on reads MOSI data bits SHALL be 0.
REQ-013 cmd_ready SHALL be high only in IDLE; a command is accepted on the cycle cmd_valid && cmd_ready, and all cmd_* fields are latched then.
REQ-014 FSM states SHALL be IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE; busy high in every state except IDLE.
REQ-015 SETUP SHALL drive cs[cmd_cs] low, sclk = CPOL, and last CLK_DIV cycles.
REQ-016 SHIFT SHALL generate FRAME_W sclk periods of 2*CLK_DIV cycles; CPHA=0: MOSI valid before leading edge, sample on leading edge; CPHA=1: MOSI changes on leading edge, sample on trailing edge.
REQ-017 MISO SHALL be captured into the read shift register only during the last DATA_W bits.
REQ-018 HOLD SHALL keep cs low and sclk = CPOL for CLK_DIV cycles; DONE SHALL release cs high and pulse rsp_valid for one cycle.
REQ-019 rsp_valid SHALL assert exactly CLK_DIV*(2*FRAME_W+2)+1 cycles after acceptance (57 at defaults).
REQ-020 rsp_rdata SHALL hold the captured byte on reads, 0 on writes, and remain stable until the next rsp_valid.
REQ-021 cmd_cs >= NUM_CS SHALL be rejected: no cs or sclk activity, rsp_valid with rsp_err=1 exactly 1 cycle after acceptance.
REQ-022 There is no response back-pressure; rsp_valid SHALL never stall the FSM.
REQ-023 In IDLE: sclk = latched CPOL of last command (0 after reset), mosi = 0, all cs high.

Reset
REQ-024 On irstn low, asynchronously: state IDLE, cs all 1, sclk 0, mosi 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, busy 0, cmd_ready 0 while reset asserted and 1 from the first cycle after release.
REQ-025 Reset mid-frame SHALL deassert cs immediately, discard the frame, and produce no rsp_valid.

Configuration
REQ-026 Macro SPI_MODE_SEL_EN defined: cmd_cpol/cmd_cpha honoured per command; undefined: ports present but ignored, fixed mode 0 (CPOL=0, CPHA=0).

Structure
REQ-027 Package spi_pkg SHALL hold the FSM state enum, the command struct type and the FRAME_W function/constants.
REQ-028 Sub-module spi_clk_gen SHALL produce sclk plus one-cycle leading/trailing edge strobes from CLK_DIV and CPOL.

Verification
REQ-029 Defaults, mode 0, write cs=2 addr=0xA data=0x5C -> cs[2] low only, MOSI bits 0_1010_01011100, rsp_valid at cycle 57, rsp_rdata 0x00.
REQ-030 Read cs=1 addr=0x3, slave model returns 0xA7 -> rsp_rdata 0xA7, rsp_err 0, MOSI data bits all 0.
REQ-031 SPI_MODE_SEL_EN, all four CPOL/CPHA modes with write/read 0x3C back-to-back -> readback 0x3C each; idle sclk equals CPOL.
REQ-032 NUM_CS=3, cmd_cs=3 -> cs stays 3'b111, rsp_err 1 one cycle after acceptance.
REQ-033 irstn pulsed low at sclk edge 6 of a write -> cs all high same cycle, no rsp_valid, next command completes normally.
REQ-034 cmd_valid held high for 3 commands -> each accepted only in IDLE, cs high >= 1 cycle between frames.
